// File: rtl/mem_word_reader_pkg.sv
// mem_word_reader_pkg
// Shared definitions for the memory driver's word buffer (read and write sides).
// Contents:
//   state_e         - read-side controller states
//   BYTES_PER_WORD  - bytes packed into one memory word
//   DEFAULT_*       - default buffer geometry
package mem_word_reader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_BYTE_W = 8;
  localparam int DEFAULT_DATA_W = BYTES_PER_WORD * DEFAULT_BYTE_W;

endpackage

// File: rtl/mem_word_reader_unpacker.sv
// mem_word_reader_unpacker
// Holds one fetched memory word and presents its bytes, least significant
// first, on a valid/ready stream.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-low reset
//   load       - capture rd_data and restart at byte 0 on this edge
//   active     - controller is in its byte-output state
//   rd_data    - memory read data
//   ready      - downstream accepts data_8 when valid_out & ready
//   data_8     - current byte (0 when not active)
//   valid_out  - byte valid
//   word_done  - last byte of the word is being accepted this cycle
import mem_word_reader_pkg::*;

module mem_word_reader_unpacker #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BYTE_W = DEFAULT_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ready,
  output logic [BYTE_W-1:0] data_8,
  output logic              valid_out,
  output logic              word_done
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              accept;

  always_comb begin
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    accept     = active & ready;
    if (load) begin
      word_d     = rd_data;
      byte_idx_d = '0;
    end else if (accept) begin
      byte_idx_d = byte_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // The byte index only moves on acceptance, so a stalled byte holds
  // naturally; forcing zero outside the active state keeps idle output quiet.
  assign valid_out = active;
  assign data_8    = active ? word_q[byte_idx_q*BYTE_W +: BYTE_W] : '0;
  assign word_done = accept && (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_word_reader.sv
// mem_word_reader
// Read-side driver for the word buffer. A rising edge on start drains every
// word between the read pointer and the writer's word count, one memory read
// per word, emitting each word as four bytes on an 8-bit valid/ready stream.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-low reset
//   start      - level request; its 0->1 edge starts a burst when idle
//   wr_count   - writer's word pointer, free-running mod 2*DEPTH
//   rd_en      - memory read strobe
//   rd_addr    - memory read address
//   rd_data    - memory read data, one cycle after rd_en
//   data_8     - output byte
//   valid_out  - data_8 valid
//   ready      - downstream ready
//   mem_empty  - read pointer has caught up with wr_count
//   busy       - burst in progress
//   done       - one-cycle pulse at end of burst
import mem_word_reader_pkg::*;

module mem_word_reader #(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BYTE_W = DEFAULT_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   wr_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [BYTE_W-1:0] data_8,
  output logic              valid_out,
  input  logic              ready,
  output logic              mem_empty,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = ADDR_W + 1;

  state_e           state_q, state_d;
  logic             start_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             start_edge;
  logic             word_done;

  assign start_edge = start & ~start_q;
  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

  // The extra pointer bit distinguishes a full buffer from an empty one, so
  // the full width is compared while only the low bits address memory.
  assign mem_empty = (rd_ptr_q == wr_count);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE:  if (start_edge && !mem_empty) state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT:  state_d = SHIFT;
      SHIFT: begin
        if (word_done) begin
          rd_ptr_d = rd_ptr_inc;
          // wr_count is re-checked per word so words written mid-burst drain too.
          state_d  = (rd_ptr_inc == wr_count) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_en   = (state_q == REQ);
  assign rd_addr = rd_en ? rd_ptr_q[ADDR_W-1:0] : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  mem_word_reader_unpacker #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == WAIT),
    .active    (state_q == SHIFT),
    .rd_data   (rd_data),
    .ready     (ready),
    .data_8    (data_8),
    .valid_out (valid_out),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_mem_word_reader.sv
module tb_mem_word_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int BYTE_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   wr_count = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [BYTE_W-1:0] data_8;
  logic              valid_out;
  logic              ready = 1'b1;
  logic              mem_empty;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  mem_word_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wr_count  (wr_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .data_8    (data_8),
    .valid_out (valid_out),
    .ready     (ready),
    .mem_empty (mem_empty),
    .busy      (busy),
    .done      (done)
  );

  // Registered-read word buffer driven by the bench.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int errors = 0;
  int checks = 0;

  // Reference model: every written word becomes four bytes, LSB first, in write order.
  logic [7:0] exp_q [$];
  bit         mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, valid_out}, 32'd1);
        check("stall_data", {24'd0, data_8}, {24'd0, prev_data});
      end
      if (rd_en) check("rd_en_nonempty", {31'd0, mem_empty}, 32'd0);
      if (mon_en && valid_out && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", data_8, $time);
        end else begin
          check("sb_byte", {24'd0, data_8}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stall <= valid_out && !ready;
      prev_data  <= data_8;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] w);
    mem[wr_count[ADDR_W-1:0]] = w;
    wr_count = wr_count + 5'd1;
    if (mon_en)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wr_count = '0;
    start = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  // Cycle-exact burst with ready held high: per word REQ, WAIT, 4 bytes; then DONE.
  task automatic run_exact(input string tag, input int a0, input int n, input logic [7:0] eb [8]);
    ready = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 6 * n + 2; k++) begin
      int w;
      int ph;
      tick();
      if (k == 1) start = 1'b0;
      w  = (k - 1) / 6;
      ph = (k - 1) % 6;
      if (k == 6 * n + 1) begin
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_done_valid"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_empty"}, {31'd0, mem_empty}, 32'd1);
      end else if (k == 6 * n + 2) begin
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      end else if (ph == 0) begin
        check({tag, "_rd_en"}, {31'd0, rd_en}, 32'd1);
        check({tag, "_rd_addr"}, {28'd0, rd_addr}, 32'((a0 + w) % DEPTH));
      end else if (ph == 1) begin
        check({tag, "_wait_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({tag, "_wait_valid"}, {31'd0, valid_out}, 32'd0);
      end else begin
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        check({tag, "_byte"}, {24'd0, data_8}, {24'd0, eb[w * 4 + ph - 2]});
      end
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  vec_t       tbl [3];
  logic [7:0] eb [8];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'hA1B2C3D4, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    tbl[1] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
    tbl[2] = '{32'hFFFF0000, 8'h00, 8'h00, 8'hFF, 8'hFF};

    // Reset values with reset held.
    tick();
    tick();
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
    check("rst_data_8", {24'd0, data_8}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, mem_empty}, 32'd1);
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("empty_start_rd_en", {31'd0, rd_en}, 32'd0);
      check("empty_start_done", {31'd0, done}, 32'd0);
      tick();
    end

    // Table of single-word bursts.
    for (int i = 0; i < 3; i++) begin
      write_word(tbl[i].word);
      eb[0] = tbl[i].b0; eb[1] = tbl[i].b1; eb[2] = tbl[i].b2; eb[3] = tbl[i].b3;
      for (int j = 4; j < 8; j++) eb[j] = 8'h00;
      run_exact($sformatf("tbl%0d", i), i, 1, eb);
    end

    // Backpressure on byte C3 for five cycles.
    write_word(32'hA1B2C3D4);
    start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      ready = !(k >= 4 && k <= 8);
      if (k == 1) check("bp_rd_addr", {28'd0, rd_addr}, 32'd3);
      if (k == 3) check("bp_b0", {24'd0, data_8}, 32'hD4);
      if (k >= 4 && k <= 9) begin
        check("bp_hold_valid", {31'd0, valid_out}, 32'd1);
        check("bp_hold_b1", {24'd0, data_8}, 32'hC3);
      end
      if (k == 10) check("bp_b2", {24'd0, data_8}, 32'hB2);
      if (k == 11) check("bp_b3", {24'd0, data_8}, 32'hA1);
      if (k == 11) check("bp_not_done_early", {31'd0, done}, 32'd0);
      if (k == 12) check("bp_done", {31'd0, done}, 32'd1);
      if (k == 13) check("bp_done_pulse", {31'd0, done}, 32'd0);
    end
    ready = 1'b1;

    // Pointer wrap: 15 prior reads, then words at addresses 15 and 0.
    do_reset();
    for (int i = 0; i < 15; i++) write_word($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("pre_wrap", 200);
    tick();
    write_word(32'h000000FF);
    write_word(32'h11112222);
    eb[0] = 8'hFF; eb[1] = 8'h00; eb[2] = 8'h00; eb[3] = 8'h00;
    eb[4] = 8'h22; eb[5] = 8'h22; eb[6] = 8'h11; eb[7] = 8'h11;
    run_exact("wrap", 15, 2, eb);

    // Word written mid-burst extends the burst without a new start.
    do_reset();
    write_word(32'hCAFEBABE);
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 4) write_word(32'h0BADF00D);
      if (k == 7) begin
        check("mid_no_done", {31'd0, done}, 32'd0);
        check("mid_rd_en", {31'd0, rd_en}, 32'd1);
        check("mid_rd_addr", {28'd0, rd_addr}, 32'd1);
      end
      if (k == 9) check("mid_w1_b0", {24'd0, data_8}, 32'h0D);
      if (k == 12) check("mid_w1_b3", {24'd0, data_8}, 32'h0B);
      if (k == 13) check("mid_done", {31'd0, done}, 32'd1);
    end

    // Reset during WAIT abandons the word and rewinds the pointer.
    write_word(32'h55667788);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, valid_out}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_empty", {31'd0, mem_empty}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rstmid_reread_en", {31'd0, rd_en}, 32'd1);
    check("rstmid_reread_addr", {28'd0, rd_addr}, 32'd0);
    wait_done("rstmid", 100);
    tick();

    // Randomized bursts against the byte-stream model.
    do_reset();
    mon_en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int nw;
      int cyc;
      nw = $urandom_range(0, 6);
      for (int i = 0; i < nw; i++) write_word($urandom);
      ready = ($urandom_range(0, 3) != 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (exp_q.size() == 0) begin
        tick();
        check("rnd_empty_idle", {31'd0, busy}, 32'd0);
        check("rnd_empty_done", {31'd0, done}, 32'd0);
        continue;
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
        ready = ($urandom_range(0, 3) != 0);
        if (busy && !done && $urandom_range(0, 9) == 0 && (exp_q.size() + 3) / 4 < 12)
          write_word($urandom);
        if (busy && !done && $urandom_range(0, 7) == 0) start = ~start;
        tick();
        cyc++;
      end
      check("rnd_done", {31'd0, done}, 32'd1);
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
      check("rnd_mem_empty", {31'd0, mem_empty}, 32'd1);
      start = 1'b0;
      tick();
    end
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
